// File: rtl/synth_voice.sv
// synth_voice: phase-accumulator oscillator, tick-driven envelope, first-order delta-sigma pin driver.
// Outputs registered (sample 1 clk after strobe), no backpressure; `define SYNTH_VOICE_NOISE_EN builds the LFSR noise wave.
module synth_voice #(
  parameter int unsigned PHASE_W      = 16,
  parameter logic [7:0]  ATTACK_STEP  = 8'd32,
  parameter logic [7:0]  DECAY_STEP   = 8'd4,
  parameter logic [7:0]  SUSTAIN      = 8'd160,
  parameter logic [7:0]  RELEASE_STEP = 8'd8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_clk,
  input  logic               i_tick_clk,
  input  logic               i_note_on,
  input  logic               i_note_off,
  input  logic [PHASE_W-1:0] i_pitch,
  input  logic [1:0]         i_wave,
  output logic [12:0]        o_audio_sample,
  output logic               o_audio_out,
  output logic [7:0]         o_env_level,
  output logic               o_active
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_DECAY   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] WAVE_SAW = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [8:0] DEC_FLOOR = {1'b0, SUSTAIN} + {1'b0, DECAY_STEP};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_env;
  logic [7:0]         w_env_nxt;
  logic               r_active;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_pitch_q;
  logic [1:0]         r_wave_q;
  logic [8:0]         w_top;
  logic [7:0]         w_raw;
  logic [12:0]        w_scaled;
  logic [12:0]        r_sample;
  logic [12:0]        r_ds_acc;
  logic [13:0]        w_ds_sum;
  logic               r_ds_out;
  logic [8:0]         w_atk_sum;
  logic               w_atk_full;
  logic               w_dec_floor;
  logic               w_rel_empty;
  logic               w_note_off_ok;

  // ---------------- envelope FSM ----------------
  assign w_atk_sum     = {1'b0, r_env} + {1'b0, ATTACK_STEP};
  assign w_atk_full    = (w_atk_sum >= 9'd255);
  assign w_dec_floor   = ({1'b0, r_env} < DEC_FLOOR);
  assign w_rel_empty   = (r_env <= RELEASE_STEP);
  assign w_note_off_ok = i_note_off && ((r_state == S_ATTACK) || (r_state == S_DECAY));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_env    <= 8'd0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_env    <= w_env_nxt;
      r_active <= (w_state_nxt != S_IDLE);
    end
  end

  // note_on beats note_off, and a taken note event swallows a coincident tick
  always_comb begin
    w_state_nxt = r_state;
    if (i_note_on) begin
      w_state_nxt = S_ATTACK;
    end else if (w_note_off_ok) begin
      w_state_nxt = S_RELEASE;
    end else if (i_tick_clk) begin
      case (r_state)
        S_ATTACK:  if (w_atk_full)  w_state_nxt = S_DECAY;
        S_RELEASE: if (w_rel_empty) w_state_nxt = S_IDLE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_env_nxt = r_env;
    if (!i_note_on && !w_note_off_ok && i_tick_clk) begin
      case (r_state)
        S_ATTACK:  w_env_nxt = w_atk_full ? 8'hFF : w_atk_sum[7:0];
        S_DECAY:   w_env_nxt = w_dec_floor ? SUSTAIN : (r_env - DECAY_STEP);
        S_RELEASE: w_env_nxt = w_rel_empty ? 8'd0 : (r_env - RELEASE_STEP);
        default:   w_env_nxt = r_env;
      endcase
    end
  end

  // ---------------- oscillator ----------------
`ifdef SYNTH_VOICE_NOISE_EN
  logic [PHASE_W:0] w_phase_sum;
  logic [14:0]      r_lfsr;

  assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_pitch_q};

  // advances once per phase wrap, so noise "pitch" follows the note pitch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 15'h0001;
    end else if (i_sample_clk && !i_note_on && w_phase_sum[PHASE_W]) begin
      r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
    end
  end
`else
  logic [PHASE_W-1:0] w_phase_sum;

  assign w_phase_sum = r_phase + r_pitch_q;
`endif

  assign w_top = r_phase[PHASE_W-1 -: 9];

  always_comb begin
    w_raw = {8{w_top[8]}};
    case (r_wave_q)
      WAVE_SAW: w_raw = w_top[8:1];
      WAVE_TRI: w_raw = w_top[8] ? ~w_top[7:0] : w_top[7:0];
`ifdef SYNTH_VOICE_NOISE_EN
      2'd3:     w_raw = r_lfsr[7:0];
`endif
      default:  w_raw = {8{w_top[8]}};
    endcase
  end

  assign w_scaled = 13'((16'(w_raw) * 16'(r_env)) >> 3);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase   <= '0;
      r_pitch_q <= '0;
      r_wave_q  <= 2'd0;
      r_sample  <= 13'd0;
    end else begin
      if (i_sample_clk) begin
        r_sample <= (r_state == S_IDLE) ? 13'd0 : w_scaled;
      end
      if (i_note_on) begin
        r_phase   <= '0;
        r_pitch_q <= i_pitch;
        r_wave_q  <= i_wave;
      end else if (i_sample_clk) begin
        r_phase <= w_phase_sum[PHASE_W-1:0];
      end
    end
  end

  // ---------------- delta-sigma ----------------
  assign w_ds_sum = {1'b0, r_ds_acc} + {1'b0, r_sample};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ds_acc <= 13'd0;
      r_ds_out <= 1'b0;
    end else begin
      r_ds_acc <= w_ds_sum[12:0];
      r_ds_out <= w_ds_sum[13];
    end
  end

  assign o_audio_sample = r_sample;
  assign o_audio_out    = r_ds_out;
  assign o_env_level    = r_env;
  assign o_active       = r_active;

endmodule

// File: tb/tb_synth_voice.sv
// Directed bench for synth_voice: arithmetic reference model checked every cycle, plus hand-computed literals.
module tb_synth_voice;

  logic        clk = 1'b0;
  logic        rst, samp, tick, non, noff;
  logic [15:0] pitch;
  logic [1:0]  wave;
  logic [12:0] audio_sample;
  logic        audio_out;
  logic [7:0]  env_level;
  logic        active;

  always #5 clk = ~clk;

  synth_voice dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_clk   (samp),
    .i_tick_clk     (tick),
    .i_note_on      (non),
    .i_note_off     (noff),
    .i_pitch        (pitch),
    .i_wave         (wave),
    .o_audio_sample (audio_sample),
    .o_audio_out    (audio_out),
    .o_env_level    (env_level),
    .o_active       (active)
  );

  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_REL = 3;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ones   = 0;
  bit rst_lvl, auto_samp, samp_pend, tick_pend, on_pend, off_pend;

  // reference model state
  int m_st, m_env, m_phase, m_pitch, m_wave, m_lfsr, m_sample, m_acc, m_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic lit(input string name, input int dut_v, input int model_v, input int exp);
    chk({name, "/dut"}, dut_v, exp);
    chk({name, "/model"}, model_v, exp);
  endtask

  function automatic int raw_val(input int ph, input int wv);
    int hi;
    int mid;
    hi  = ph / 32768;
    mid = (ph / 128) % 256;
    case (wv)
      1: return (ph / 256) % 256;
      2: return (hi != 0) ? 255 - mid : mid;
`ifdef SYNTH_VOICE_NOISE_EN
      3: return m_lfsr % 256;
`endif
      default: return (hi != 0) ? 255 : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_env = 0; m_phase = 0; m_pitch = 0; m_wave = 0;
    m_lfsr = 1; m_sample = 0; m_acc = 0; m_out = 0;
  endtask

  task automatic model_edge();
    int tot;
    int sum;
    int fb;
    if (rst) begin
      model_reset();
      return;
    end
    tot   = m_acc + m_sample;
    m_out = (tot >= 8192) ? 1 : 0;
    m_acc = tot % 8192;
    if (samp) m_sample = (m_st == M_IDLE) ? 0 : (raw_val(m_phase, m_wave) * m_env) / 8;
    if (non) begin
      m_phase = 0;
    end else if (samp) begin
      sum = m_phase + m_pitch;
      if (sum >= 65536) begin
        fb     = ((m_lfsr / 16384) % 2) ^ ((m_lfsr / 8192) % 2);
        m_lfsr = (m_lfsr * 2 + fb) % 32768;
      end
      m_phase = sum % 65536;
    end
    if (non) begin
      m_st = M_ATK; m_pitch = int'(pitch); m_wave = int'(wave);
    end else if (noff && (m_st == M_ATK || m_st == M_DEC)) begin
      m_st = M_REL;
    end else if (tick) begin
      case (m_st)
        M_ATK: if (m_env + 32 >= 255) begin m_env = 255; m_st = M_DEC; end
               else m_env = m_env + 32;
        M_DEC: m_env = (m_env - 4 < 160) ? 160 : m_env - 4;
        M_REL: if (m_env - 8 <= 0) begin m_env = 0; m_st = M_IDLE; end
               else m_env = m_env - 8;
        default: ;
      endcase
    end
  endtask

  // every clock: drive, advance model at the edge, compare on the falling edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      rst  = rst_lvl;
      samp = samp_pend || (auto_samp && (cyc % 4 == 0));
      tick = tick_pend;
      non  = on_pend;
      noff = off_pend;
      samp_pend = 0; tick_pend = 0; on_pend = 0; off_pend = 0;
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      if (audio_out) ones++;
      chk("audio_sample", int'(audio_sample), m_sample);
      chk("audio_out", int'(audio_out), m_out);
      chk("env_level", int'(env_level), m_env);
      chk("active", int'(active), int'(m_st != M_IDLE));
    end
  endtask

  task automatic do_tick();
    tick_pend = 1;
    step(4);
  endtask

  task automatic do_sample();
    samp_pend = 1;
    step(1);
  endtask

  task automatic note(input logic [15:0] p, input logic [1:0] w);
    pitch = p; wave = w; on_pend = 1;
    step(1);
  endtask

  int atk_tab[8] = '{32, 64, 96, 128, 160, 192, 224, 255};
  int sq_tab[8]  = '{0, 0, 8128, 8128, 0, 0, 8128, 8128};
  int saw_tab[5] = '{0, 31, 63, 95, 127};
  int tri_tab[6] = '{0, 2040, 4080, 6120, 8128, 6088};

  initial begin
    pitch = 16'h0; wave = 2'd0;
    rst = 1'b1; samp = 1'b0; tick = 1'b0; non = 1'b0; noff = 1'b0;
    rst_lvl = 1; auto_samp = 0; samp_pend = 0; tick_pend = 0; on_pend = 0; off_pend = 0;
    model_reset();

    step(3);
    lit("rst_sample", int'(audio_sample), m_sample, 0);
    lit("rst_out", int'(audio_out), m_out, 0);
    lit("rst_env", int'(env_level), m_env, 0);
    lit("rst_active", int'(active), int'(m_st != M_IDLE), 0);

    // idle 2000 clocks with strobes running
    rst_lvl = 0; auto_samp = 1; ones = 0;
    for (int i = 0; i < 40; i++) begin
      tick_pend = 1;
      step(50);
    end
    chk("idle_ones", ones, 0);
    lit("idle_active", int'(active), int'(m_st != M_IDLE), 0);

    // attack ramp, square wave
    auto_samp = 0;
    note(16'h4000, 2'd0);
    lit("atk_active", int'(active), int'(m_st != M_IDLE), 1);
    for (int i = 0; i < 8; i++) begin
      tick_pend = 1;
      step(1);
      lit($sformatf("atk_env%0d", i), int'(env_level), m_env, atk_tab[i]);
      step(2);
    end
    lit("atk_to_decay", m_st, m_st, M_DEC);
    for (int i = 0; i < 8; i++) begin
      do_sample();
      lit($sformatf("square%0d", i), int'(audio_sample), m_sample, sq_tab[i]);
    end

    // saw retrigger with env held at 255
    note(16'h0100, 2'd1);
    lit("saw_env_kept", int'(env_level), m_env, 255);
    for (int i = 0; i < 5; i++) begin
      do_sample();
      lit($sformatf("saw%0d", i), int'(audio_sample), m_sample, saw_tab[i]);
    end
    auto_samp = 1;
    step(400);
    auto_samp = 0;

    note(16'h2000, 2'd2);
    for (int i = 0; i < 6; i++) begin
      do_sample();
      lit($sformatf("tri%0d", i), int'(audio_sample), m_sample, tri_tab[i]);
    end

    note(16'h8000, 2'd3);
    for (int i = 0; i < 3; i++) begin
      do_sample();
`ifndef SYNTH_VOICE_NOISE_EN
      lit($sformatf("wave3_square%0d", i), int'(audio_sample), m_sample, (i == 1) ? 8128 : 0);
`endif
    end

    // decay to sustain, then release to idle
    auto_samp = 1;
    do_tick();
    lit("decay_enter", int'(env_level), m_env, 255);
    for (int i = 1; i <= 24; i++) begin
      do_tick();
      if (i == 1) lit("decay_first", int'(env_level), m_env, 251);
    end
    lit("sustain", int'(env_level), m_env, 160);
    do_tick();
    lit("sustain_hold", int'(env_level), m_env, 160);
    off_pend = 1;
    step(1);
    lit("rel_active", int'(active), int'(m_st != M_IDLE), 1);
    for (int i = 1; i <= 20; i++) begin
      do_tick();
      if (i == 19) begin
        lit("rel_env19", int'(env_level), m_env, 8);
        lit("rel_active19", int'(active), int'(m_st != M_IDLE), 1);
      end
    end
    lit("rel_env20", int'(env_level), m_env, 0);
    lit("rel_idle", int'(active), int'(m_st != M_IDLE), 0);
    auto_samp = 0;
    step(4);
    do_sample();
    lit("idle_sample", int'(audio_sample), m_sample, 0);

    // constant 2048 sample: exactly a quarter of the clocks carry
    note(16'h4000, 2'd2);
    for (int i = 0; i < 4; i++) do_tick();
    lit("ds_env", int'(env_level), m_env, 128);
    do_sample();
    do_sample();
    lit("ds_sample", int'(audio_sample), m_sample, 2048);
    step(3);
    ones = 0;
    step(1024);
    chk("ds_ones_2048", ones, 256);

    // release, then note_on + note_off together
    off_pend = 1;
    step(1);
    do_tick();
    do_tick();
    lit("rel2_env", int'(env_level), m_env, 112);
    pitch = 16'h1000; wave = 2'd1; on_pend = 1; off_pend = 1;
    step(1);
    lit("both_env", int'(env_level), m_env, 112);
    lit("both_active", int'(active), int'(m_st != M_IDLE), 1);
    do_sample();
    lit("both_phase0", int'(audio_sample), m_sample, 0);
    do_sample();
    lit("both_saw", int'(audio_sample), m_sample, 224);
    do_tick();
    lit("both_attack", int'(env_level), m_env, 144);

    // reset mid-note with strobes asserted
    rst_lvl = 1; tick_pend = 1; on_pend = 1; samp_pend = 1;
    step(1);
    rst_lvl = 0;
    lit("midrst_env", int'(env_level), m_env, 0);
    lit("midrst_active", int'(active), int'(m_st != M_IDLE), 0);
    lit("midrst_sample", int'(audio_sample), m_sample, 0);
    step(5);
    lit("midrst_out", int'(audio_out), m_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
